hkspi_passthru_mux: RTL and testbench
=====================================

# hkspi_passthru_mux

Multi-channel housekeeping SPI pass-thru bridge for the management SoC. Samples the host housekeeping SPI pins in the core `clock` domain and decodes the first command byte of each transaction. It then either forwards the rest of the transaction to one of `N_CH` downstream SPI targets (channel 0 = boot flash), or hands the command to the housekeeping register engine. While a selected target is being accessed, the block holds the CPU in reset and releases it after a programmable delay.

## Interface
- `N_CH`, 2: number of downstream channels (2..16).
- `CPU_HOLD_MASK`, `{{N_CH-1{1'b0}},1'b1}`: per-channel bit; a set bit means `cpu_hold` is asserted while that channel is active.
- `HOLD_EXT`, 16: clocks `cpu_hold` stays high after the pass-thru transaction ends (≥1).

Ports:
- `clock`  in  1  core clock.
- `reset`  in  1  synchronous, active-high reset.
- `host_csb`, `host_sck`, `host_sdi`  in  1 each  host SPI pins; asynchronous to `clock`.
- `host_sdo`  out  1  data returned to the host.
- `host_sdo_oe`  out  1  high only in PASS.
- `ch_csb`  out  N_CH  downstream chip selects, active low.
- `ch_sck`, `ch_mosi`  out  1 each  downstream clock and data, shared by all channels.
- `ch_miso`  in  N_CH  downstream return data.
- `cmd_valid`  out  1  one-cycle pulse when a non-pass-thru command byte is complete.
- `cmd_byte`  out  8  that command byte; held until the next `cmd_valid`.
- `reg_busy`  out  1  high in REG; the register engine owns the host SDO.
- `cpu_hold`  out  1  CPU reset request.
- `pt_active`  out  1  high in PASS.
- `pt_channel`  out  4  selected channel; held after PASS ends.
- `byte_count`  out  16  complete bytes forwarded since PASS entry; saturates at 0xFFFF.

## Operation
- Input conditioning:
  - `host_csb`, `host_sck` and `host_sdi` each pass through a 2-flop synchronizer.
  - Edge detection runs on the synchronized SCK (`sck_s`).
- FSM states: IDLE, CMD, PASS, REG, SKIP.
- IDLE → CMD when synchronized CSB goes low. The bit counter and shift register are cleared.
- CMD: shift the synchronized SDI MSB-first on each `sck_s` rising edge. The cycle after the 8th rising edge, decode the byte:
  - 0xC4 → channel 0.
  - 0xC2 → channel 1.
  - 0xD0|k → channel k, where k < N_CH.
  - Any valid channel → PASS.
  - 0xD0|k with k ≥ N_CH → SKIP.
  - Any other byte → REG, with `cmd_valid` pulsing and `cmd_byte` loaded.
- PASS entry:
  - `ch_csb[k]` goes low.
  - `pt_channel` = k.
  - `byte_count` is cleared.
  - `cpu_hold` is set if `CPU_HOLD_MASK[k]`.
- PASS forwarding:
  - `ch_sck` = `sck_s` registered; `ch_mosi` = synchronized SDI registered.
  - `ch_sck` is gated low until the first `sck_s` falling edge after entry. This suppresses the tail of the command byte's 8th clock.
  - `host_sdo` = `ch_miso[k]` registered; `host_sdo_oe` = 1.
  - A modulo-8 counter on forwarded rising edges increments `byte_count` on each 8th edge.
- Any state other than IDLE → IDLE when synchronized CSB goes high. In the same cycle:
  - all `ch_csb` go high;
  - `ch_sck` and `ch_mosi` go 0;
  - `host_sdo_oe`, `pt_active` and `reg_busy` go 0.
  - A partial byte is not counted.
- `cpu_hold` timer: loaded with `HOLD_EXT` on the PASS→IDLE transition. `cpu_hold` clears when the timer reaches 0.
- A new transaction during the hold is permitted and re-enters CMD normally. Re-entering PASS on a masked channel stops the timer and keeps `cpu_hold` high.
- SKIP: downstream stays deselected, `host_sdo_oe` = 0, and all bits are ignored until CSB goes high.
- Reset values:
  - State IDLE.
  - `ch_csb` all ones.
  - `ch_sck`, `ch_mosi`, `host_sdo`, `host_sdo_oe`, `cmd_valid`, `reg_busy`, `cpu_hold`, `pt_active` = 0.
  - `cmd_byte`, `pt_channel`, `byte_count` = 0.
- Reset asserted mid-PASS forces these values on the next edge and cancels the hold timer, so `cpu_hold` drops immediately.

## Timing
- Host pin to `ch_sck`/`ch_mosi`: 3 clocks (2 sync stages + output register).
- Host CSB high to `ch_csb` high: 3 clocks.
- `ch_miso` to `host_sdo`: 1 clock.
- Host SCK high and low phases must each be ≥ 6 clocks. With the downstream device's clock-to-out < 1 clock, `host_sdo` is then valid before the next host rising edge.
- Host CSB setup and hold to SCK must each be ≥ 3 clocks.
- Command decode, `cmd_valid` and PASS entry occur 1 clock after the 8th synchronized rising edge.
- `cpu_hold` falls exactly `HOLD_EXT` clocks after the PASS→IDLE transition.

## Test plan
- Reset with random pins → every output at its listed reset value; `ch_csb` = 2'b11.
- Send 0xC4, 0x03, 0x00, 0x00, 0x00, then read 8 bytes, with the channel-0 flash model holding 6F 00 00 0B 13 00 00 00 → the host reads those bytes in order, `ch_csb` = 2'b10, `cpu_hold` = 1, `byte_count` = 12 at CSB rise, and `cpu_hold` falls 16 clocks after IDLE.
- Send 0xC2 (and separately 0xD1) → `ch_csb` = 2'b01, `pt_channel` = 1, `cpu_hold` stays 0, the model's 0xA5 reply is seen on `host_sdo`.
- Send 0x40 → a single `cmd_valid` pulse, `cmd_byte` = 0x40, `reg_busy` = 1 until CSB high, `host_sdo_oe` = 0, no `ch_csb` activity.
- With N_CH = 2, send 0xD5 → SKIP, `ch_csb` stays 2'b11, `byte_count` unchanged; the following 0x40 transaction still decodes correctly.
- Raise CSB after 3 bits of the 2nd PASS byte → `ch_csb` high 3 clocks later and `byte_count` = 1. Assert `reset` mid-PASS → all outputs at reset values on the next edge, with `cpu_hold` = 0 immediately.

Source files
------------

// File: rtl/hkspi_passthru_mux.sv
// Housekeeping SPI pass-thru bridge: synchronizes the host SPI pins, decodes the
// first command byte and either forwards the transaction downstream or hands it to the register engine.
module hkspi_passthru_mux #(
    parameter int                N_CH          = 2,
    parameter logic [N_CH-1:0]   CPU_HOLD_MASK = {{(N_CH-1){1'b0}}, 1'b1},
    parameter int                HOLD_EXT      = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            host_csb,
    input  logic            host_sck,
    input  logic            host_sdi,
    output logic            host_sdo,
    output logic            host_sdo_oe,
    output logic [N_CH-1:0] ch_csb,
    output logic            ch_sck,
    output logic            ch_mosi,
    input  logic [N_CH-1:0] ch_miso,
    output logic            cmd_valid,
    output logic [7:0]      cmd_byte,
    output logic            reg_busy,
    output logic            cpu_hold,
    output logic            pt_active,
    output logic [3:0]      pt_channel,
    output logic [15:0]     byte_count
);

    localparam int TW = $clog2(HOLD_EXT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_PASS,
        ST_REG,
        ST_SKIP
    } state_e;

    // Selects bit idx of a per-channel vector; out-of-range indices read as 0.
    function automatic logic bit_at(input logic [N_CH-1:0] v, input logic [3:0] idx);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (idx == 4'(i)) r = v[i];
        end
        return r;
    endfunction

    logic csb_meta_q, csb_s_q;
    logic sck_meta_q, sck_s_q, sck_prev_q;
    logic sdi_meta_q, sdi_s_q;

    state_e          state_q,      state_d;
    logic [2:0]      bit_cnt_q,    bit_cnt_d;
    logic [7:0]      shift_q,      shift_d;
    logic [3:0]      chan_q,       chan_d;
    logic            armed_q,      armed_d;
    logic [2:0]      fwd_cnt_q,    fwd_cnt_d;
    logic [15:0]     byte_count_q, byte_count_d;
    logic            cmd_valid_q,  cmd_valid_d;
    logic [7:0]      cmd_byte_q,   cmd_byte_d;
    logic            hold_q,       hold_d;
    logic [TW-1:0]   timer_q,      timer_d;
    logic [N_CH-1:0] ch_csb_q,     ch_csb_d;
    logic            ch_sck_q,     ch_sck_d;
    logic            ch_mosi_q,    ch_mosi_d;
    logic            host_sdo_q,   host_sdo_d;

    logic       sck_rise, sck_fall;
    logic [7:0] cmd_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            csb_meta_q <= 1'b1;
            csb_s_q    <= 1'b1;
            sck_meta_q <= 1'b0;
            sck_s_q    <= 1'b0;
            sck_prev_q <= 1'b0;
            sdi_meta_q <= 1'b0;
            sdi_s_q    <= 1'b0;
        end else begin
            csb_meta_q <= host_csb;
            csb_s_q    <= csb_meta_q;
            sck_meta_q <= host_sck;
            sck_s_q    <= sck_meta_q;
            sck_prev_q <= sck_s_q;
            sdi_meta_q <= host_sdi;
            sdi_s_q    <= sdi_meta_q;
        end
    end

    assign sck_rise = sck_s_q & ~sck_prev_q;
    assign sck_fall = ~sck_s_q & sck_prev_q;
    assign cmd_next = {shift_q[6:0], sdi_s_q};

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        chan_d       = chan_q;
        armed_d      = armed_q;
        fwd_cnt_d    = fwd_cnt_q;
        byte_count_d = byte_count_q;
        cmd_valid_d  = 1'b0;
        cmd_byte_d   = cmd_byte_q;
        hold_d       = hold_q;
        timer_d      = timer_q;

        if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
            if (timer_q == TW'(1)) hold_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (!csb_s_q) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            ST_CMD: begin
                if (csb_s_q) begin
                    state_d = ST_IDLE;
                end else if (sck_rise) begin
                    shift_d   = cmd_next;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (cmd_next == 8'hC4 || cmd_next == 8'hC2 ||
                            (cmd_next[7:4] == 4'hD && int'(cmd_next[3:0]) < N_CH)) begin
                            state_d      = ST_PASS;
                            chan_d       = (cmd_next == 8'hC4) ? 4'd0 :
                                           (cmd_next == 8'hC2) ? 4'd1 : cmd_next[3:0];
                            armed_d      = 1'b0;
                            fwd_cnt_d    = '0;
                            byte_count_d = '0;
                            if (bit_at(CPU_HOLD_MASK, chan_d)) begin
                                hold_d  = 1'b1;
                                timer_d = '0;
                            end
                        end else if (cmd_next[7:4] == 4'hD) begin
                            state_d = ST_SKIP;
                        end else begin
                            state_d     = ST_REG;
                            cmd_valid_d = 1'b1;
                            cmd_byte_d  = cmd_next;
                        end
                    end
                end
            end
            ST_PASS: begin
                if (csb_s_q) begin
                    state_d = ST_IDLE;
                    armed_d = 1'b0;
                    if (bit_at(CPU_HOLD_MASK, chan_q)) timer_d = TW'(HOLD_EXT);
                end else begin
                    // The first falling edge ends the command byte's 8th clock.
                    if (sck_fall) armed_d = 1'b1;
                    if (sck_rise && armed_q) begin
                        fwd_cnt_d = fwd_cnt_q + 3'd1;
                        if (fwd_cnt_q == 3'd7 && byte_count_q != 16'hFFFF)
                            byte_count_d = byte_count_q + 16'd1;
                    end
                end
            end
            ST_REG, ST_SKIP: begin
                if (csb_s_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        for (int i = 0; i < N_CH; i++) begin
            ch_csb_d[i] = !(state_d == ST_PASS && chan_d == 4'(i));
        end
        ch_sck_d   = (state_d == ST_PASS) && armed_d && sck_s_q;
        ch_mosi_d  = (state_d == ST_PASS) && armed_d && sdi_s_q;
        host_sdo_d = (state_d == ST_PASS) && bit_at(ch_miso, chan_d);
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            chan_q       <= '0;
            armed_q      <= 1'b0;
            fwd_cnt_q    <= '0;
            byte_count_q <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_byte_q   <= '0;
            hold_q       <= 1'b0;
            timer_q      <= '0;
            ch_csb_q     <= '1;
            ch_sck_q     <= 1'b0;
            ch_mosi_q    <= 1'b0;
            host_sdo_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            chan_q       <= chan_d;
            armed_q      <= armed_d;
            fwd_cnt_q    <= fwd_cnt_d;
            byte_count_q <= byte_count_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_byte_q   <= cmd_byte_d;
            hold_q       <= hold_d;
            timer_q      <= timer_d;
            ch_csb_q     <= ch_csb_d;
            ch_sck_q     <= ch_sck_d;
            ch_mosi_q    <= ch_mosi_d;
            host_sdo_q   <= host_sdo_d;
        end
    end

    assign host_sdo    = host_sdo_q;
    assign host_sdo_oe = (state_q == ST_PASS);
    assign pt_active   = (state_q == ST_PASS);
    assign reg_busy    = (state_q == ST_REG);
    assign ch_csb      = ch_csb_q;
    assign ch_sck      = ch_sck_q;
    assign ch_mosi     = ch_mosi_q;
    assign cmd_valid   = cmd_valid_q;
    assign cmd_byte    = cmd_byte_q;
    assign cpu_hold    = hold_q;
    assign pt_channel  = chan_q;
    assign byte_count  = byte_count_q;

endmodule

// File: tb/tb_hkspi_passthru_mux.sv
// Directed bench for hkspi_passthru_mux: bit-banged host SPI, a channel-0 read-only
// flash model and a channel-1 target that always answers 0xA5.
module tb_hkspi_passthru_mux;

    localparam int PH = 8;
    localparam logic [7:0] C1_PAT = 8'hA5;

    logic        clock = 1'b0;
    logic        reset;
    logic        host_csb, host_sck, host_sdi;
    logic        host_sdo, host_sdo_oe;
    logic [1:0]  ch_csb;
    logic        ch_sck, ch_mosi;
    logic [1:0]  ch_miso;
    logic        cmd_valid;
    logic [7:0]  cmd_byte;
    logic        reg_busy, cpu_hold, pt_active;
    logic [3:0]  pt_channel;
    logic [15:0] byte_count;

    int n_vec  = 0;
    int n_miss = 0;

    hkspi_passthru_mux #(.N_CH(2), .CPU_HOLD_MASK(2'b01), .HOLD_EXT(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .host_csb   (host_csb),
        .host_sck   (host_sck),
        .host_sdi   (host_sdi),
        .host_sdo   (host_sdo),
        .host_sdo_oe(host_sdo_oe),
        .ch_csb     (ch_csb),
        .ch_sck     (ch_sck),
        .ch_mosi    (ch_mosi),
        .ch_miso    (ch_miso),
        .cmd_valid  (cmd_valid),
        .cmd_byte   (cmd_byte),
        .reg_busy   (reg_busy),
        .cpu_hold   (cpu_hold),
        .pt_active  (pt_active),
        .pt_channel (pt_channel),
        .byte_count (byte_count)
    );

    always #5 clock = ~clock;

    // Channel 0: mode-0 flash answering a 0x03 read with its 8-byte image.
    logic        fl_csb, fl_miso;
    int          fl_bits;
    logic [31:0] fl_in;
    logic [23:0] fl_addr;
    logic [7:0]  fl_mem [8];
    logic [2:0]  fl_idx, fl_bit;
    assign fl_csb = ch_csb[0];
    assign fl_idx = 3'(fl_addr) + 3'((fl_bits - 32) / 8);
    assign fl_bit = 3'(7 - ((fl_bits - 32) % 8));

    always @(posedge ch_sck or posedge fl_csb) begin
        if (fl_csb) begin
            fl_bits <= 0;
        end else begin
            fl_in   <= {fl_in[30:0], ch_mosi};
            if (fl_bits == 31) fl_addr <= {fl_in[22:0], ch_mosi};
            fl_bits <= fl_bits + 1;
        end
    end

    always @(negedge ch_sck or posedge fl_csb) begin
        if (fl_csb) fl_miso <= 1'b0;
        else if (fl_bits >= 32) fl_miso <= fl_mem[fl_idx][fl_bit];
    end

    // Channel 1: shifts 0xA5 out on every byte.
    logic       c1_csb;
    logic [2:0] c1_cnt;
    assign c1_csb = ch_csb[1];
    always @(negedge ch_sck or posedge c1_csb) begin
        if (c1_csb) c1_cnt <= '0;
        else c1_cnt <= c1_cnt + 3'd1;
    end
    assign ch_miso = {(!c1_csb && C1_PAT[3'd7 - c1_cnt]), fl_miso};

    int cv_cnt  = 0;
    int act_cnt = 0;
    always @(negedge clock) begin
        if (cmd_valid === 1'b1) cv_cnt <= cv_cnt + 1;
        if (reset === 1'b0 && ch_csb !== 2'b11) act_cnt <= act_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            host_sdi = tx[i];
            repeat (PH) @(negedge clock);
            rx[i] = host_sdo;
            host_sck = 1'b1;
            repeat (PH) @(negedge clock);
            host_sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        host_csb = 1'b0;
        repeat (PH) @(negedge clock);
    endtask

    task automatic cs_high();
        repeat (PH) @(negedge clock);
        host_csb = 1'b1;
        repeat (2 * PH) @(negedge clock);
    endtask

    logic [7:0] exp_rd [8];
    logic [7:0] rx;
    logic [7:0] pt_cmds [2];
    int n, cv0, act0;

    initial begin
        exp_rd = '{8'h6F, 8'h00, 8'h00, 8'h0B, 8'h13, 8'h00, 8'h00, 8'h00};
        fl_mem = exp_rd;
        pt_cmds = '{8'hC2, 8'hD1};

        // Reset with random host pins
        reset    = 1'b1;
        host_csb = 1'($urandom);
        host_sck = 1'($urandom);
        host_sdi = 1'($urandom);
        repeat (4) @(negedge clock);
        check("rst_ch_csb",      32'(ch_csb),      'h3);
        check("rst_ch_sck",      32'(ch_sck),      'h0);
        check("rst_ch_mosi",     32'(ch_mosi),     'h0);
        check("rst_host_sdo",    32'(host_sdo),    'h0);
        check("rst_host_sdo_oe", 32'(host_sdo_oe), 'h0);
        check("rst_cmd_valid",   32'(cmd_valid),   'h0);
        check("rst_reg_busy",    32'(reg_busy),    'h0);
        check("rst_cpu_hold",    32'(cpu_hold),    'h0);
        check("rst_pt_active",   32'(pt_active),   'h0);
        check("rst_cmd_byte",    32'(cmd_byte),    'h0);
        check("rst_pt_channel",  32'(pt_channel),  'h0);
        check("rst_byte_count",  32'(byte_count),  'h0);
        host_csb = 1'b1;
        host_sck = 1'b0;
        host_sdi = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        repeat (8) @(negedge clock);

        // Boot flash read through channel 0
        cs_low();
        spi_bits(8'hC4, 8, rx);
        check("c4_ch_csb",   32'(ch_csb),      'h2);
        check("c4_cpu_hold", 32'(cpu_hold),    'h1);
        check("c4_sdo_oe",   32'(host_sdo_oe), 'h1);
        check("c4_pt_chan",  32'(pt_channel),  'h0);
        spi_bits(8'h03, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 8, rx);
        for (int j = 0; j < 8; j++) begin
            spi_bits(8'h00, 8, rx);
            check($sformatf("flash_rd%0d", j), 32'(rx), 32'(exp_rd[j]));
        end
        repeat (PH) @(negedge clock);
        host_csb = 1'b1;
        n = 0;
        while (pt_active !== 1'b0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("c4_exit", 32'(pt_active), 'h0);
        check("c4_ch_csb_exit", 32'(ch_csb), 'h3);
        check("c4_hold_at_exit", 32'(cpu_hold), 'h1);
        n = 0;
        while (cpu_hold !== 1'b0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("c4_hold_fall_clks", 32'(n), 16);
        check("c4_byte_count", 32'(byte_count), 12);
        repeat (2 * PH) @(negedge clock);

        // Channel 1 via both its command encodings
        for (int c = 0; c < 2; c++) begin
            cs_low();
            spi_bits(pt_cmds[c], 8, rx);
            check($sformatf("ch1_csb_%0h", pt_cmds[c]),  32'(ch_csb),     'h1);
            check($sformatf("ch1_chan_%0h", pt_cmds[c]), 32'(pt_channel), 'h1);
            check($sformatf("ch1_hold_%0h", pt_cmds[c]), 32'(cpu_hold),   'h0);
            spi_bits(8'h00, 8, rx);
            check($sformatf("ch1_rd_%0h", pt_cmds[c]), 32'(rx), 'hA5);
            cs_high();
            check($sformatf("ch1_bc_%0h", pt_cmds[c]), 32'(byte_count), 'h1);
        end

        // Register-engine command
        cv0  = cv_cnt;
        act0 = act_cnt;
        cs_low();
        spi_bits(8'h40, 8, rx);
        check("reg_busy",     32'(reg_busy),    'h1);
        check("reg_sdo_oe",   32'(host_sdo_oe), 'h0);
        check("reg_cmd_byte", 32'(cmd_byte),    'h40);
        spi_bits(8'hFF, 8, rx);
        check("reg_busy_2nd", 32'(reg_busy), 'h1);
        cs_high();
        check("reg_busy_end", 32'(reg_busy), 'h0);
        check("reg_cv_pulses", 32'(cv_cnt - cv0), 'h1);
        check("reg_no_csb",    32'(act_cnt - act0), 'h0);

        // Out-of-range channel then a normal register command
        cv0  = cv_cnt;
        act0 = act_cnt;
        cs_low();
        spi_bits(8'hD5, 8, rx);
        spi_bits(8'hC4, 8, rx);
        check("skip_ch_csb", 32'(ch_csb),      'h3);
        check("skip_sdo_oe", 32'(host_sdo_oe), 'h0);
        check("skip_busy",   32'(reg_busy),    'h0);
        cs_high();
        check("skip_bc",       32'(byte_count),      'h1);
        check("skip_no_csb",   32'(act_cnt - act0),  'h0);
        check("skip_no_cv",    32'(cv_cnt - cv0),    'h0);
        cs_low();
        spi_bits(8'h40, 8, rx);
        check("post_skip_busy", 32'(reg_busy), 'h1);
        cs_high();
        check("post_skip_cv",  32'(cv_cnt - cv0), 'h1);
        check("post_skip_cmd", 32'(cmd_byte),     'h40);

        // CSB raised three bits into the second forwarded byte
        cs_low();
        spi_bits(8'hC4, 8, rx);
        spi_bits(8'h9C, 8, rx);
        spi_bits(8'hA0, 3, rx);
        repeat (PH) @(negedge clock);
        host_csb = 1'b1;
        n = 0;
        while (ch_csb[0] !== 1'b1 && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("part_csb_clks", 32'(n),          3);
        check("part_bc",       32'(byte_count), 'h1);
        check("part_ch_sck",   32'(ch_sck),     'h0);
        check("part_ch_mosi",  32'(ch_mosi),    'h0);
        repeat (4 * PH) @(negedge clock);

        // Reset in the middle of a pass-thru transaction
        cs_low();
        spi_bits(8'hC4, 8, rx);
        spi_bits(8'h05, 8, rx);
        check("mid_hold",   32'(cpu_hold),   'h1);
        check("mid_bc",     32'(byte_count), 'h1);
        reset = 1'b1;
        @(negedge clock);
        check("mrst_hold",      32'(cpu_hold),    'h0);
        check("mrst_ch_csb",    32'(ch_csb),      'h3);
        check("mrst_pt_active", 32'(pt_active),   'h0);
        check("mrst_sdo_oe",    32'(host_sdo_oe), 'h0);
        check("mrst_bc",        32'(byte_count),  'h0);
        check("mrst_cmd_byte",  32'(cmd_byte),    'h0);
        host_csb = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        repeat (8) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
